// File: rtl/p15_envelope_ctrl_if.sv
// Register bus between a host and the envelope controller.
// The host drives the strobes, address and write data. The controller returns registered read data.
interface p15_envelope_ctrl_if;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic [7:0] rd_data;

  modport master (
    output wr_en,
    output rd_en,
    output addr,
    output data_in,
    input  rd_data
  );

  modport slave (
    input  wr_en,
    input  rd_en,
    input  addr,
    input  data_in,
    output rd_data
  );
endinterface

// File: rtl/p15_envelope_ctrl.sv
// Envelope register controller: decodes R11/R12/R13 and double-buffers the period.
// Every R13 write sequences a generator restart: a reset pulse, then alignment to the prescaler tick.
module p15_envelope_ctrl #(
  parameter int unsigned PERIOD_BITS  = 16,
  parameter int unsigned RESET_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  p15_envelope_ctrl_if.slave     bus,
  output logic [PERIOD_BITS-1:0] period,
  output logic                   hold,
  output logic                   alternate,
  output logic                   attack,
  output logic                   continue_,
  output logic                   env_reset,
  output logic                   busy
);
  localparam int unsigned CW      = PERIOD_BITS - 8;
  localparam logic [3:0]  CntLoad = 4'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPulse, StAlign} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [7:0]    r_fine;
  logic [CW-1:0] r_coarse;
  logic [3:0]    r_shape;
  logic          r_pending;

  logic          w_wr_fine;
  logic          w_wr_coarse;
  logic          w_wr_shape;
  logic          w_commit;
  logic [7:0]    w_fine_nxt;
  logic [CW-1:0] w_coarse_nxt;
  logic [7:0]    w_rd_val;

  always_comb begin
    w_wr_fine    = bus.wr_en && (bus.addr == 4'd11);
    w_wr_coarse  = bus.wr_en && (bus.addr == 4'd12);
    w_wr_shape   = bus.wr_en && (bus.addr == 4'd13);
    // Forward same-cycle shadow writes so a commit never takes a stale byte
    w_fine_nxt   = w_wr_fine ? bus.data_in : r_fine;
    w_coarse_nxt = w_wr_coarse ? CW'(bus.data_in) : r_coarse;
    w_commit     = ((r_state == StIdle) && enable && (r_pending || w_wr_fine || w_wr_coarse)) ||
                   ((r_state == StPulse) && (r_cnt == 4'd0) && !w_wr_shape);
  end

  always_comb begin
    w_rd_val = 8'h00;
    case (bus.addr)
      4'd11:   w_rd_val = r_fine;
      4'd12:   w_rd_val = 8'(r_coarse);
      4'd13:   w_rd_val = {4'b0000, r_shape};
      default: w_rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_fine      <= 8'h00;
      r_coarse    <= '0;
      r_shape     <= 4'b0000;
      r_pending   <= 1'b0;
      period      <= '0;
      env_reset   <= 1'b0;
      busy        <= 1'b0;
      bus.rd_data <= 8'h00;
    end else begin
      if (w_wr_fine)   r_fine   <= bus.data_in;
      if (w_wr_coarse) r_coarse <= CW'(bus.data_in);
      if (bus.rd_en)   bus.rd_data <= w_rd_val;

      if (w_commit) begin
        period    <= {w_coarse_nxt, w_fine_nxt};
        r_pending <= 1'b0;
      end else if (w_wr_fine || w_wr_coarse) begin
        r_pending <= 1'b1;
      end

      // An R13 write (re)starts the pulse from any state
      if (w_wr_shape) begin
        r_shape   <= bus.data_in[3:0];
        r_state   <= StPulse;
        r_cnt     <= CntLoad;
        env_reset <= 1'b1;
        busy      <= 1'b1;
      end else begin
        unique case (r_state)
          StPulse: begin
            if (r_cnt == 4'd0) begin
              r_state   <= StAlign;
              env_reset <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          StAlign: begin
            if (enable) begin
              r_state <= StIdle;
              busy    <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign hold      = r_shape[0];
  assign alternate = r_shape[1];
  assign attack    = r_shape[2];
  assign continue_ = r_shape[3];
endmodule

// File: tb/tb_p15_envelope_ctrl.sv
// Bench for p15_envelope_ctrl: a behavioural model is checked against the DUT on every cycle.
// Directed vectors also carry literal expectations.
module tb_p15_envelope_ctrl;
  localparam int RC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] period;
  logic        hold, alternate, attack, continue_, env_reset, busy;

  int checks = 0;
  int errors = 0;

  p15_envelope_ctrl_if bus ();

  p15_envelope_ctrl #(.PERIOD_BITS(16), .RESET_CYCLES(RC)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus),
    .period    (period),
    .hold      (hold),
    .alternate (alternate),
    .attack    (attack),
    .continue_ (continue_),
    .env_reset (env_reset),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Model state. m_since counts edges since the last R13 write. env_reset is high while
  // m_since < RC. busy stays high until the first tick after the pulse has ended.
  logic [7:0]  m_fine, m_coarse, m_rd, m_nf, m_nc;
  logic [3:0]  m_shape;
  logic [15:0] m_period;
  logic        m_pending, m_busy, m_wf, m_wc, m_ws, m_commit;
  int          m_since;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_fine = 0; m_coarse = 0; m_rd = 0; m_shape = 0; m_period = 0;
      m_pending = 0; m_busy = 0; m_since = 1000;
    end else begin
      m_wf = bus.wr_en && bus.addr == 4'd11;
      m_wc = bus.wr_en && bus.addr == 4'd12;
      m_ws = bus.wr_en && bus.addr == 4'd13;
      m_nf = m_wf ? bus.data_in : m_fine;
      m_nc = m_wc ? bus.data_in : m_coarse;
      if (bus.rd_en)
        m_rd = (bus.addr == 4'd11) ? m_fine :
               (bus.addr == 4'd12) ? m_coarse :
               (bus.addr == 4'd13) ? {4'b0, m_shape} : 8'h00;
      m_commit = (!m_busy && enable && (m_pending || m_wf || m_wc)) ||
                 (m_busy && m_since == RC - 1 && !m_ws);
      m_fine = m_nf;
      m_coarse = m_nc;
      if (m_commit) begin
        m_period = {m_nc, m_nf};
        m_pending = 0;
      end else if (m_wf || m_wc) begin
        m_pending = 1;
      end
      if (m_ws) begin
        m_shape = bus.data_in[3:0];
        m_since = 0;
        m_busy = 1;
      end else begin
        if (m_busy && m_since >= RC && enable) m_busy = 0;
        if (m_since < 1000) m_since++;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("model period", period, m_period);
      chk("model shape", {12'h0, continue_, attack, alternate, hold}, {12'h0, m_shape});
      chk("model env_reset", {15'h0, env_reset}, {15'h0, m_since < RC});
      chk("model busy", {15'h0, busy}, {15'h0, m_busy});
      chk("model rd_data", {8'h0, bus.rd_data}, {8'h0, m_rd});
    end
  end

  // All tasks start and end on a falling edge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.wr_en = 1; bus.addr = a; bus.data_in = d;
    @(negedge clk);
    bus.wr_en = 0;
  endtask

  task automatic rd(input logic [3:0] a);
    bus.rd_en = 1; bus.addr = a;
    @(negedge clk);
    bus.rd_en = 0;
  endtask

  task automatic tick();
    enable = 1;
    @(negedge clk);
    enable = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic count_env(output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (env_reset) n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    bus.wr_en = 0; bus.rd_en = 0; bus.addr = 0; bus.data_in = 0;
    idle(2);
    reset = 0;
    idle(2);
    chk("reset period", period, 16'h0000);
    chk("reset busy", {15'h0, busy}, 16'h0);
    chk("reset env", {15'h0, env_reset}, 16'h0);
    chk("reset rd", {8'h0, bus.rd_data}, 16'h0);

    // Double-buffered period
    wr(4'd11, 8'h34);
    wr(4'd12, 8'h12);
    idle(2);
    chk("period before tick", period, 16'h0000);
    tick();
    chk("period after tick", period, 16'h1234);
    rd(4'd12);
    chk("read R12", {8'h0, bus.rd_data}, 16'h0012);

    // Restart with shape 0xFE
    wr(4'd13, 8'hFE);
    chk("shape FE", {12'h0, continue_, attack, alternate, hold}, 16'h000E);
    count_env(n);
    chk("env width", 16'(n), 16'd2);
    chk("busy in align", {15'h0, busy}, 16'h1);
    tick();
    chk("busy after tick", {15'h0, busy}, 16'h0);
    rd(4'd13);
    chk("read R13", {8'h0, bus.rd_data}, 16'h000E);

    // Retrigger in PULSE stretches into a single 3-clock pulse
    wr(4'd13, 8'h05);
    wr(4'd13, 8'h0A);
    chk("env still high", {15'h0, env_reset}, 16'h1);
    count_env(n);
    chk("retrig width", 16'(n + 1), 16'd3);
    chk("retrig shape", {12'h0, continue_, attack, alternate, hold}, 16'h000A);
    tick();

    // R11 write during PULSE commits at PULSE->ALIGN
    wr(4'd13, 8'h00);
    wr(4'd11, 8'hFF);
    chk("period pre-align", period, 16'h1234);
    idle(1);
    chk("period at align", period, 16'h12FF);
    tick();
    chk("period post tick", period, 16'h12FF);

    // Write and tick in the same IDLE cycle
    bus.wr_en = 1; bus.addr = 4'd11; bus.data_in = 8'h56; enable = 1;
    @(negedge clk);
    bus.wr_en = 0; enable = 0;
    chk("wr+tick period", period, 16'h1256);

    // Read and write of one register in the same cycle returns the old value
    bus.wr_en = 1; bus.rd_en = 1; bus.addr = 4'd12; bus.data_in = 8'h77;
    @(negedge clk);
    bus.wr_en = 0; bus.rd_en = 0;
    chk("rd pre-write", {8'h0, bus.rd_data}, 16'h0012);
    chk("pending hold", period, 16'h1256);
    tick();
    chk("pending commit", period, 16'h7756);

    // Unmapped addresses
    wr(4'd5, 8'hAA);
    rd(4'd5);
    chk("unmapped rd", {8'h0, bus.rd_data}, 16'h0000);
    chk("unmapped busy", {15'h0, busy}, 16'h0);

    // Asynchronous reset in the middle of a pulse
    wr(4'd13, 8'h03);
    #2 reset = 1;
    #1;
    chk("abort env", {15'h0, env_reset}, 16'h0);
    chk("abort busy", {15'h0, busy}, 16'h0);
    chk("abort period", period, 16'h0000);
    @(negedge clk);
    reset = 0;
    idle(1);
    tick();
    chk("no commit after reset", period, 16'h0000);
    chk("no env after reset", {15'h0, env_reset}, 16'h0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/p15_envelope_ctrl.md
Name: p15_envelope_ctrl

Overview:
Register-side controller for the envelope generator. It decodes bus writes and reads to envelope registers R11 (period fine), R12 (period coarse) and R13 (shape). It drives the generator's period and shape inputs. It sequences the envelope restart that every R13 write triggers: a reset pulse, then realignment to the prescaler tick. Period updates are double-buffered so the generator never sees a half-written 16-bit period.

Parameters:
PERIOD_BITS, 16, width of the period output; fine byte is bits [7:0], coarse is bits [PERIOD_BITS-1:8]
RESET_CYCLES, 2, clocks for which env_reset is held high per restart (legal range 1..15)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  prescaler tick shared with the envelope generator; one-cycle pulse
wr_en  input  1  write strobe, sampled on rising clk
rd_en  input  1  read strobe, sampled on rising clk
addr  input  4  register address
data_in  input  8  write data
rd_data  output  8  registered read data
period  output  PERIOD_BITS  committed envelope period, to generator
hold  output  1  shape bit 0
alternate  output  1  shape bit 1
attack  output  1  shape bit 2
continue_  output  1  shape bit 3
env_reset  output  1  synchronous restart pulse to the envelope generator; OR'd with the system reset at the generator
busy  output  1  high while a restart sequence is in progress

Behaviour:
- Reset (async) sets the following:
  - period = 0, shadow fine/coarse = 0, shape = 4'b0000, rd_data = 0
  - env_reset = 0, busy = 0, state = IDLE, pending = 0
- Writes (wr_en=1), decoded by addr:
  - 11: shadow_fine <= data_in; pending <= 1.
  - 12: shadow_coarse <= data_in[PERIOD_BITS-9:0]; pending <= 1.
  - 13: shape <= data_in[3:0] on the next edge; restart sequence starts, see FSM.
  - Other addresses are ignored. data_in[7:4] on R13 is ignored.
- Period commit: period <= {shadow_coarse, shadow_fine} and pending <= 0, on the first of:
  - an enable tick in IDLE with pending=1, or
  - the PULSE->ALIGN transition, regardless of pending.
- A write to R11/R12 and an enable in the same cycle: the write lands in the shadow. The commit uses the new shadow value, so the written byte is in period one cycle later.
- Reads: rd_data updates one clock after rd_en.
  - addr 11 reads shadow_fine. addr 12 reads zero-extended shadow_coarse.
  - addr 13 reads {4'b0, shape}. Other addresses read 0.
  - rd_data holds its value when rd_en=0.
  - rd_en and wr_en to the same address in the same cycle: rd_data returns the pre-write value.
- FSM states: IDLE, PULSE, ALIGN.
  - IDLE: wr_en && addr==13 -> PULSE. env_reset=1 and busy=1 from the next edge; cnt <= RESET_CYCLES-1.
  - PULSE: env_reset=1 and busy=1. If cnt==0 -> ALIGN (env_reset=0, period commit); else cnt decrements.
  - ALIGN: env_reset=0, busy=1. On enable -> IDLE, busy=0. This guarantees the generator's first count starts on a full prescaler tick.
  - An R13 write in PULSE or ALIGN retriggers: state PULSE, cnt reloaded, shape updated. This takes priority over a simultaneous enable or cnt==0.
- env_reset is high for exactly RESET_CYCLES consecutive clocks after the last R13 write.
- Shape outputs change on the same edge env_reset first rises, so the generator samples the new attack during its reset.
- R11/R12 writes during PULSE/ALIGN are buffered. They are included in the PULSE->ALIGN commit if written before it, otherwise committed by the IDLE rule.
- Async reset mid-sequence aborts it immediately. All outputs return to reset values with no residual pulse.

Test Plan:
- After reset, no traffic -> period=0, shape=0, env_reset=0, busy=0, rd_data=0.
- Write R11=0x34 then R12=0x12, with no enable between; then one enable pulse -> period stays 0 until the enable edge, then becomes 0x1234 in one step; read R12 gives 0x12 one cycle after rd_en.
- Write R13=0xFE with RESET_CYCLES=2 -> shape = 4'b1110 and env_reset=1 for exactly 2 clocks; busy stays 1 until the first enable after env_reset falls, then 0; read R13 gives 0x0E.
- Write R13 at cycle t, then again at t+1 (during PULSE) -> env_reset high continuously through t+3 (a single pulse of 3 clocks); shape equals the second value.
- Write R11=0xFF during PULSE -> period updated at the PULSE->ALIGN edge without waiting for enable; pending cleared; no further change on the next enable.
- Assert reset asynchronously (mid-cycle) during PULSE -> env_reset, busy and period go to 0 immediately; after release, an enable produces no commit.
